// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multi-cycle sequencer.
//   state_e    - sequencer states (IDLE, MUL, DIV, DONE)
//   F3_*       - funct3 encodings of the M-extension ops
//   XLEN_DEF   - default operand width
//   DIV0_QUOT  - quotient returned for division by zero
//   INT_MIN    - most negative XLEN value (signed-overflow result)
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEF-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between ex_stage and muldiv_seq.
//   start  - EX holds a valid M op (level, held while stalled)
//   funct3 - M op select
//   a, b   - rs1 / rs2 operands
//   flush  - kill the in-flight op
//   stall  - freeze IF/ID/EX
//   busy   - sequencer not idle
//   done   - one-cycle result-valid pulse
//   result - op result, held until the next done
// Modports: master (pipeline side), slave (sequencer side).
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      - partial remainder (always < divisor)
//   dvd_msb  - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   next_rem - partial remainder after this step
//   q_bit    - quotient bit produced by this step
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic            q_bit
);
  // The shifted remainder can need XLEN+1 bits; the difference never does,
  // since rem < divisor implies shifted < 2*divisor.
  logic [XLEN:0] shifted;

  always_comb begin
    shifted  = {rem, dvd_msb};
    q_bit    = (shifted >= {1'b0, divisor});
    next_rem = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer (registered multiply, 32-step
// restoring divider) sitting beside the ALU in EX.
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - muldiv_seq_if.slave (start/funct3/a/b/flush in,
//          stall/busy/done/result out)
// Optional build macro MULDIV_FAST_PATH_EN: divide-by-zero and signed
// overflow resolve in IDLE and finish one cycle after acceptance.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned DIV_STEPS = XLEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);
  localparam int unsigned CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fix_q, fix_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [2*XLEN-1:0] ax, bx, prod;
  logic              a_sgn, b_sgn, in_rem, q_neg;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[XLEN-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Sign flags are zero for unsigned operands, so the extension below
  // covers signed, unsigned and the mixed MULHSU case uniformly.
  assign ax   = {{XLEN{a_neg_q}}, a_q};
  assign bx   = {{XLEN{b_neg_q}}, b_q};
  assign prod = ax * bx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      fix_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      fix_q    <= fix_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    fix_d    = fix_q;
    result_d = result_q;
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    in_rem   = 1'b0;
    q_neg    = 1'b0;
    quot_fix = '0;
    rem_fix  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          a_sgn   = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                    (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
          b_sgn   = (bus.funct3 == F3_MULH) ||
                    (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
          in_rem  = (bus.funct3 == F3_REM) || (bus.funct3 == F3_REMU);
          f3_d    = bus.funct3;
          a_d     = bus.a;
          b_d     = bus.b;
          a_neg_d = a_sgn && bus.a[XLEN-1];
          b_neg_d = b_sgn && bus.b[XLEN-1];
          if (!bus.funct3[2]) begin
            state_d = MUL;
          end else begin
            dvd_d   = (a_sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
            dvs_d   = (b_sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;
            quot_d  = '0;
            rem_d   = '0;
            cnt_d   = CW'(DIV_STEPS - 1);
            fix_d   = 1'b0;
            state_d = DIV;
`ifdef MULDIV_FAST_PATH_EN
            if (bus.b == '0) begin
              result_d = in_rem ? bus.a : XLEN'(DIV0_QUOT);
              state_d  = DONE;
            end else if (a_sgn && (bus.a == XLEN'(INT_MIN)) && (bus.b == '1)) begin
              result_d = in_rem ? '0 : XLEN'(INT_MIN);
              state_d  = DONE;
            end
`endif
          end
        end
      end

      MUL: begin
        result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d  = DONE;
      end

      // DIV_STEPS shift/subtract cycles, then one extra DIV cycle (fix_q)
      // applies the sign fixup so the result is registered from settled
      // quotient/remainder values.
      DIV: begin
        if (!fix_q) begin
          dvd_d  = dvd_q << 1;
          rem_d  = step_rem;
          quot_d = {quot_q[XLEN-2:0], step_q};
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) fix_d = 1'b1;
        end else begin
          in_rem   = (f3_q == F3_REM) || (f3_q == F3_REMU);
          q_neg    = a_neg_q ^ b_neg_q;
          quot_fix = q_neg ? -quot_q : quot_q;
          rem_fix  = a_neg_q ? -rem_q : rem_q;
          // Divide-by-zero: raw quotient is all ones, but a negative
          // dividend would otherwise flip it.
          if (b_q == '0) quot_fix = XLEN'(DIV0_QUOT);
          result_d = in_rem ? rem_fix : quot_fix;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything: abandon the op and keep the old result.
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE) && !bus.flush;
  assign bus.stall  = ((state_q == IDLE) && bus.start && !bus.flush) ||
                      (state_q == MUL) || (state_q == DIV);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_PATH_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_seen;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  // Drives one op from the current cycle (T) and holds start until the
  // done pulse, like a stalled pipeline. lat is the cycle offset of done
  // (-1 if none within the budget); stl[k] is stall observed in cycle T+k.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic [63:0] stl);
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    bus.start  = 1'b1;
    lat = -1;
    res = '0;
    stl = '0;
    #1;
    stl[0] = bus.stall;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      stl[k] = bus.stall;
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=%h", bus.result, 32'h0); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [5]  = '{F3_MUL, F3_MULHU, F3_MULHSU, F3_MULH, F3_MULH};
    logic [31:0] va [5]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb [5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ve [5]  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h40000000};
    int lat;
    logic [31:0] res;
    logic [63:0] stl;
    for (int i = 0; i < 5; i++) begin
      run_op(f3[i], va[i], vb[i], lat, res, stl);
      n_checks++;
      if (res !== ve[i]) begin n_fail++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL mul_latency[%0d] got=%0d exp=2", i, lat); end
    end
    n_checks++;
    if (stl[2:0] !== 3'b011) begin n_fail++; $display("FAIL mul_stall got=%b exp=011", stl[2:0]); end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] va [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
    logic [31:0] vb [4] = '{32'd3, 32'd3, 32'd7, 32'd7};
    logic [31:0] ve [4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2};
    logic [34:0] stall_exp;
    int lat;
    logic [31:0] res;
    logic [63:0] stl;
    stall_exp = {1'b0, {34{1'b1}}};
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], va[i], vb[i], lat, res, stl);
      n_checks++;
      if (res !== ve[i]) begin n_fail++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      n_checks++;
      if (lat !== 34) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d exp=34", i, lat); end
      if (i == 0) begin
        n_checks++;
        if (stl[34:0] !== stall_exp) begin n_fail++; $display("FAIL div_stall got=%b exp=%b", stl[34:0], stall_exp); end
      end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3 [6] = '{F3_DIV, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM};
    logic [31:0] va [6] = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    logic [31:0] vb [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ve [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'h0};
    int lat;
    logic [31:0] res;
    logic [63:0] stl;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], va[i], vb[i], lat, res, stl);
      n_checks++;
      if (res !== ve[i]) begin n_fail++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      n_checks++;
      if (lat !== SPECIAL_LAT) begin n_fail++; $display("FAIL special_latency[%0d] got=%0d exp=%0d", i, lat, SPECIAL_LAT); end
    end
  endtask

  task automatic test_flush();
    int lat;
    int d0;
    logic [31:0] res;
    logic [63:0] stl;
    logic [31:0] prev;
    prev = bus.result;
    d0 = done_seen;
    bus.funct3 = F3_DIVU;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    bus.start  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got=%b exp=1", bus.busy); end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
    n_checks++;
    if (bus.result !== prev) begin n_fail++; $display("FAIL flush_result got=%h exp=%h", bus.result, prev); end
    @(posedge clk); #1;
    n_checks++;
    if (done_seen !== d0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=%0d", done_seen, d0); end
    run_op(F3_MUL, 32'd6, 32'd7, lat, res, stl);
    n_checks++;
    if (res !== 32'd42) begin n_fail++; $display("FAIL flush_next_mul got=%h exp=%h", res, 32'd42); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL flush_next_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    logic [63:0] stl;
    bus.funct3 = F3_DIV;
    bus.a      = 32'd77;
    bus.b      = 32'd5;
    bus.start  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(F3_DIVU, 32'd77, 32'd5, lat, res, stl);
    n_checks++;
    if (res !== 32'd15) begin n_fail++; $display("FAIL rstmid_next_div got=%h exp=%h", res, 32'd15); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int d0;
    logic [31:0] res;
    logic [63:0] stl;
    d0 = done_seen;
    run_op(F3_REMU, 32'd100, 32'd7, lat, res, stl);
    n_checks++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", res, 32'd2); end
    run_op(F3_MUL, 32'd3, 32'd5, lat, res, stl);
    n_checks++;
    if (res !== 32'd15) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", res, 32'd15); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done_seen !== d0 + 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=%0d", done_seen - d0, 2); end
    n_checks++;
    if (bus.result !== 32'd15) begin n_fail++; $display("FAIL b2b_result_hold got=%h exp=%h", bus.result, 32'd15); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_seen  = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    bus.flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
